// File: rtl/bch_enc_scheduler.sv
// bch_enc_scheduler
//   Shares one serial BCH(N,K) encoder between N_REQ message sources.
//   A round-robin arbiter accepts one K-bit message with a single-cycle
//   req_ready pulse. The message is streamed MSB-first to the encoder, and the
//   encoder is kept running through the N-K parity cycles. GAP guard cycles
//   then let the encoder flush before the next accept.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   req_valid/data  : per-requester pending flag and K-bit message
//                     (requester i in req_data[i*K +: K])
//   req_ready       : one-hot accept pulse
//   enc_valid/bit   : info bit to the encoder (registered)
//   enc_run         : encoder advance enable (combinational from state, dn_ready)
//   enc_ready       : encoder took the info bit
//   dn_ready        : downstream can take an encoder output bit
//   frame_owner     : requester whose frame is in flight
//   busy            : accept through the last guard cycle
//   frame_done      : one-cycle pulse after the last parity cycle
//   frame_cnt       : completed frames, modulo 2^16
module bch_enc_scheduler #(
  parameter int N_REQ = 2,
  parameter int K     = 51,
  parameter int N     = 63,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*K-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     enc_valid,
  output logic                     enc_bit,
  output logic                     enc_run,
  input  logic                     enc_ready,
  input  logic                     dn_ready,
  output logic [$clog2(N_REQ)-1:0] frame_owner,
  output logic                     busy,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt
);

  localparam int              OW         = $clog2(N_REQ);
  localparam logic [5:0]      LAST_DATA  = 6'(K - 1);
  localparam logic [5:0]      LAST_PAR   = 6'(N - K - 1);
  localparam logic [2:0]      LAST_GUARD = 3'(GAP - 1);
  localparam logic [OW-1:0]   PTR_RST    = OW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_GUARD} state_t;

  state_t             state_q, state_d;
  logic [K-1:0]       shreg_q, shreg_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]         gcnt_q, gcnt_d;
  logic [OW-1:0]      last_q, last_d;
  logic [OW-1:0]      frame_owner_q, frame_owner_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic               enc_valid_q, enc_valid_d;
  logic               enc_bit_q, enc_bit_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               gnt_found;
  logic [OW-1:0]      gnt_idx;
  logic [OW-1:0]      cand;
  logic [K-1:0]       gnt_msg;
  logic               consume;
  logic               done_evt;

  // Pointer increment with wrap at N_REQ-1 (N_REQ need not be a power of 2).
  function automatic logic [OW-1:0] ptr_inc(input logic [OW-1:0] p);
    return (p == PTR_RST) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search: first pending requester starting at last+1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = ptr_inc(last_q);
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = ptr_inc(cand);
    end
  end

  // Message mux for the granted requester.
  always_comb begin
    gnt_msg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == OW'(i)) gnt_msg = req_data[i*K +: K];
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    gcnt_d        = gcnt_q;
    last_d        = last_q;
    frame_owner_d = frame_owner_q;
    frame_cnt_d   = frame_cnt_q;
    done_evt      = 1'b0;
    // enc_valid_q is high exactly while in DATA.
    consume       = enc_valid_q & enc_ready & dn_ready;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          shreg_d       = gnt_msg;
          frame_owner_d = gnt_idx;
          last_d        = gnt_idx;
          bit_cnt_d     = '0;
          state_d       = S_DATA;
        end
      end
      S_DATA: begin
        if (consume) begin
          shreg_d = {shreg_q[K-2:0], 1'b0};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (dn_ready) begin
          if (bit_cnt_q == LAST_PAR) begin
            done_evt    = 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
            bit_cnt_d   = '0;
            gcnt_d      = '0;
            state_d     = S_GUARD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_GUARD: begin
        // Encoder runs regardless of dn_ready so it can flush its state.
        if (gcnt_q == LAST_GUARD) state_d = S_IDLE;
        else                      gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: registered ones are computed from the next state; enc_run is
  // combinational so the encoder freezes in the same cycle dn_ready drops.
  always_comb begin
    req_ready_d  = '0;
    if (state_q == S_IDLE && gnt_found) req_ready_d = ONE_HOT0 << gnt_idx;
    enc_valid_d  = (state_d == S_DATA);
    enc_bit_d    = enc_valid_d & shreg_d[K-1];
    busy_d       = (state_d != S_IDLE);
    frame_done_d = done_evt;
    case (state_q)
      S_DATA, S_PARITY: enc_run = dn_ready;
      S_GUARD:          enc_run = 1'b1;
      default:          enc_run = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      gcnt_q        <= '0;
      last_q        <= PTR_RST;
      frame_owner_q <= '0;
      req_ready_q   <= '0;
      enc_valid_q   <= 1'b0;
      enc_bit_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      gcnt_q        <= gcnt_d;
      last_q        <= last_d;
      frame_owner_q <= frame_owner_d;
      req_ready_q   <= req_ready_d;
      enc_valid_q   <= enc_valid_d;
      enc_bit_q     <= enc_bit_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign enc_valid   = enc_valid_q;
  assign enc_bit     = enc_bit_q;
  assign frame_owner = frame_owner_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_bch_enc_scheduler.sv
// Directed bench for bch_enc_scheduler at default parameters (2 requesters,
// BCH(63,51), GAP=2). Inputs change 1 time unit after the rising edge and
// outputs are sampled there too.
module tb_bch_enc_scheduler;
  localparam int NR = 2;
  localparam int K  = 51;

  localparam logic [K-1:0] D0 = 51'h5_5555_5555_5555;
  localparam logic [K-1:0] D1 = 51'h2_AAAA_0F0F_3C3C;
  localparam logic [K-1:0] DS = 51'h7_1234_5678_9ABC;
  localparam logic [K-1:0] DF = 51'h7_FFFF_FFFF_FFFF;

  logic            clk, rst;
  logic [NR-1:0]   req_valid;
  logic [NR*K-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            enc_valid, enc_bit, enc_run, enc_ready, dn_ready;
  logic [0:0]      frame_owner;
  logic            busy, frame_done;
  logic [15:0]     frame_cnt;

  int total = 0;
  int bad   = 0;

  // Per-frame observations filled by frame_run.
  logic [K-1:0] f_bits;
  int f_beats, f_done_c, f_len, f_nready, f_ndone, f_stab, f_runerr, f_gcyc, f_grunbad;

  bch_enc_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_valid(enc_valid), .enc_bit(enc_bit),
    .enc_run(enc_run), .enc_ready(enc_ready), .dn_ready(dn_ready),
    .frame_owner(frame_owner), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until req_ready is seen; lat = edges waited, -1 on timeout.
  task automatic wait_grant(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (req_ready != '0) begin
        lat = i;
        break;
      end
    end
  endtask

  // Runs one frame from the accept cycle (c=0) until busy drops.
  // mode 0: no stalls; 1: dn_ready stalls (5 at 20 bits, 3 in parity);
  // mode 2: enc_ready low every 3rd cycle; 3: dn_ready low during guard.
  task automatic frame_run(input int mode);
    int c, stall, par_adv;
    bit done_seen, s1, s2, pv, pb, in_par, beat;
    logic pbit, dn, en;
    f_bits = '0; f_beats = 0; f_done_c = -1; f_len = -1; f_nready = 0;
    f_ndone = 0; f_stab = 0; f_runerr = 0; f_gcyc = 0; f_grunbad = 0;
    stall = 0; par_adv = 0; done_seen = 0; s1 = 0; s2 = 0; pv = 0; pb = 0; pbit = 0;
    for (c = 0; c < 300; c++) begin
      if (frame_done) begin
        f_ndone++;
        if (!done_seen) f_done_c = c;
        done_seen = 1;
      end
      if (!busy) begin
        f_len = c;
        break;
      end
      if (c > 0 && req_ready != '0) f_nready++;
      in_par = !enc_valid && !done_seen;
      if (mode == 1 && !s1 && enc_valid && f_beats == 20) begin s1 = 1; stall = 5; end
      if (mode == 1 && !s2 && in_par && par_adv == 5) begin s2 = 1; stall = 3; end
      dn = (stall == 0);
      if (stall > 0) stall--;
      en = 1'b1;
      if (mode == 2) en = (c % 3 != 2);
      if (mode == 3 && done_seen) dn = 1'b0;
      dn_ready = dn; enc_ready = en;
      #1;
      if (done_seen) begin
        f_gcyc++;
        if (enc_run !== 1'b1) f_grunbad++;
      end else if (enc_run !== dn) f_runerr++;
      if (pv && !pb && enc_valid && enc_bit !== pbit) f_stab++;
      beat = enc_valid && en && dn;
      if (beat) begin
        f_bits = {f_bits[K-2:0], enc_bit};
        f_beats++;
      end
      if (in_par && dn) par_adv++;
      pv = enc_valid; pb = beat; pbit = enc_bit;
      tick();
    end
    dn_ready = 1'b1; enc_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; enc_ready = 1'b1; dn_ready = 1'b1;
    tick(); tick();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
    total++; if (enc_valid !== 1'b0) begin bad++; $display("FAIL rst_enc_valid got %b want 0", enc_valid); end
    total++; if (enc_bit !== 1'b0) begin bad++; $display("FAIL rst_enc_bit got %b want 0", enc_bit); end
    total++; if (enc_run !== 1'b0) begin bad++; $display("FAIL rst_enc_run got %b want 0", enc_run); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    total++; if (frame_cnt !== 16'h0) begin bad++; $display("FAIL rst_frame_cnt got %h want 0000", frame_cnt); end
    total++; if (frame_owner !== 1'b0) begin bad++; $display("FAIL rst_owner got %b want 0", frame_owner); end
    rst = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0 || req_ready !== 2'b00) begin bad++; $display("FAIL idle_no_req busy=%b ready=%b want 0/00", busy, req_ready); end
  endtask

  task automatic test_single();
    int lat;
    req_data[0 +: K] = D0;
    req_valid = 2'b01;
    wait_grant(lat);
    req_valid = 2'b00;
    total++; if (lat !== 1) begin bad++; $display("FAIL single_latency got %0d want 1", lat); end
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got %b want 01", req_ready); end
    total++; if (enc_valid !== 1'b1 || enc_bit !== 1'b1) begin bad++; $display("FAIL single_first_bit got v=%b b=%b want 1/1", enc_valid, enc_bit); end
    frame_run(0);
    total++; if (f_bits !== D0) begin bad++; $display("FAIL single_bits got %h want %h", f_bits, D0); end
    total++; if (f_beats !== 51) begin bad++; $display("FAIL single_beats got %0d want 51", f_beats); end
    total++; if (f_done_c !== 63) begin bad++; $display("FAIL single_done_time got %0d want 63", f_done_c); end
    total++; if (f_len !== 65) begin bad++; $display("FAIL single_busy_len got %0d want 65", f_len); end
    total++; if (f_nready !== 0 || f_ndone !== 1) begin bad++; $display("FAIL single_pulses got ready=%0d done=%0d want 0/1", f_nready, f_ndone); end
    total++; if (f_runerr !== 0) begin bad++; $display("FAIL single_enc_run got %0d errs want 0", f_runerr); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_contention();
    int lat;
    logic [1:0] exp_rdy;
    rst = 1'b1; tick(); rst = 1'b0;
    req_data[0 +: K] = D0;
    req_data[K +: K] = D1;
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      exp_rdy = (f % 2 == 1) ? 2'b10 : 2'b01;
      wait_grant(lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL rr_latency[%0d] got %0d want 1", f, lat); end
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant[%0d] got %b want %b", f, req_ready, exp_rdy); end
      total++; if (frame_owner !== 1'(f % 2)) begin bad++; $display("FAIL rr_owner[%0d] got %0d want %0d", f, frame_owner, f % 2); end
      frame_run(0);
      total++; if (f_bits !== ((f % 2 == 1) ? D1 : D0)) begin bad++; $display("FAIL rr_bits[%0d] got %h", f, f_bits); end
      total++; if (f_len !== 65) begin bad++; $display("FAIL rr_len[%0d] got %0d want 65", f, f_len); end
      if (f == 3) req_valid = 2'b00;
    end
    tick();
    total++; if (req_ready !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rr_quiet got ready=%b busy=%b want 00/0", req_ready, busy); end
    total++; if (frame_cnt !== 16'd4) begin bad++; $display("FAIL rr_frame_cnt got %0d want 4", frame_cnt); end
  endtask

  task automatic test_stall();
    int lat;
    req_data[0 +: K] = DS;
    req_valid = 2'b01;
    wait_grant(lat);
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL stall_grant got %b want 01", req_ready); end
    frame_run(1);
    total++; if (f_bits !== DS) begin bad++; $display("FAIL stall_bits got %h want %h", f_bits, DS); end
    total++; if (f_beats !== 51) begin bad++; $display("FAIL stall_beats got %0d want 51", f_beats); end
    total++; if (f_stab !== 0) begin bad++; $display("FAIL stall_bit_stable got %0d changes want 0", f_stab); end
    total++; if (f_runerr !== 0) begin bad++; $display("FAIL stall_enc_run got %0d errs want 0", f_runerr); end
    total++; if (f_done_c !== 71) begin bad++; $display("FAIL stall_done_time got %0d want 71", f_done_c); end
    total++; if (f_len !== 73) begin bad++; $display("FAIL stall_len got %0d want 73", f_len); end
  endtask

  task automatic test_backpressure();
    int lat;
    req_data[K +: K] = D1;
    req_valid = 2'b10;
    wait_grant(lat);
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b10 || frame_owner !== 1'b1) begin bad++; $display("FAIL bp_grant got %b/%0d want 10/1", req_ready, frame_owner); end
    frame_run(2);
    total++; if (f_beats !== 51) begin bad++; $display("FAIL bp_beats got %0d want 51", f_beats); end
    total++; if (f_bits !== D1) begin bad++; $display("FAIL bp_bits got %h want %h", f_bits, D1); end
    total++; if (f_stab !== 0) begin bad++; $display("FAIL bp_bit_stable got %0d changes want 0", f_stab); end
    total++; if (f_done_c !== 88) begin bad++; $display("FAIL bp_done_time got %0d want 88", f_done_c); end
  endtask

  task automatic test_reset_mid();
    int lat, cyc, beats;
    req_data[0 +: K] = DF;
    req_data[K +: K] = D1;
    req_valid = 2'b01;
    wait_grant(lat);
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rmid_first_grant got %b want 01", req_ready); end
    beats = 0;
    for (cyc = 0; cyc < 100 && beats < 30; cyc++) begin
      if (enc_valid && enc_ready && dn_ready) beats++;
      if (beats < 30) tick();
      else tick();
    end
    total++; if (beats !== 30 || enc_valid !== 1'b1 || enc_bit !== 1'b1) begin bad++; $display("FAIL rmid_pre got beats=%0d v=%b b=%b want 30/1/1", beats, enc_valid, enc_bit); end
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    total++; if (enc_valid !== 1'b0 || enc_bit !== 1'b0 || enc_run !== 1'b0) begin bad++; $display("FAIL rmid_async_enc got v=%b b=%b r=%b want 0/0/0", enc_valid, enc_bit, enc_run); end
    total++; if (busy !== 1'b0 || req_ready !== 2'b00 || frame_done !== 1'b0) begin bad++; $display("FAIL rmid_async_ctl got busy=%b ready=%b done=%b want 0", busy, req_ready, frame_done); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rmid_frame_cnt got %0d want 0", frame_cnt); end
    tick();
    rst = 1'b0;
    wait_grant(lat);
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b01 || lat !== 1) begin bad++; $display("FAIL rmid_regrant got %b lat=%0d want 01 lat=1", req_ready, lat); end
    frame_run(0);
    total++; if (f_bits !== DF || frame_cnt !== 16'd1) begin bad++; $display("FAIL rmid_after got bits=%h cnt=%0d want %h/1", f_bits, frame_cnt, DF); end
  endtask

  task automatic test_wrap();
    int lat;
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    total++; if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got %h want ffff", frame_cnt); end
    req_data[0 +: K] = D0;
    req_valid = 2'b01;
    wait_grant(lat);
    req_valid = 2'b00;
    frame_run(3);
    total++; if (frame_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_frame_cnt got %h want 0000", frame_cnt); end
    total++; if (f_gcyc !== 2) begin bad++; $display("FAIL wrap_guard_len got %0d want 2", f_gcyc); end
    total++; if (f_grunbad !== 0) begin bad++; $display("FAIL wrap_guard_run got %0d bad cycles want 0", f_grunbad); end
    total++; if (f_ndone !== 1 || f_bits !== D0) begin bad++; $display("FAIL wrap_frame got done=%0d bits=%h want 1/%h", f_ndone, f_bits, D0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
